// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 32;

  // Arbiter FSM states; the encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } bus_state_t;

  // Master identifier: 0 = master 0 (CPU), 1 = master 1 (DMA/debug).
  typedef logic mid_t;

  // Operation latched at grant time.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } bus_op_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the master that was
// not granted last time wins; a single requester always wins.
module bus_rr_pick
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last_gnt,
  output logic       gnt_valid,
  output mid_t       gnt_id
);

  // Pick the winner from the request vector and the last grant.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter with round-robin on contention.
// Optional read timeout is built only when BUS_ARB_TIMEOUT_EN is defined.
//
// Handshake: a master holds rd_en/wr_en (plus addr and wr_data) high until
// it sees a one-cycle ack; ack is the only completion signal and is given
// only to the granted master. On the slave side s_rd_en/s_wr_en are
// one-cycle strobes, and s_rd_valid is honoured only while a read waits
// for data, so stale or late valid pulses are dropped.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rd_en,
  input  logic              m0_wr_en,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rd_en,
  input  logic              m1_wr_en,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_rd_en,
  output logic              s_wr_en,
  output logic [DATA_W-1:0] s_wr_data,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic              s_rd_valid,
  output logic [1:0]        o_dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
    $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  bus_state_t        r_state;
  bus_state_t        w_state_nxt;
  mid_t              r_gnt;
  mid_t              r_last_gnt;
  bus_op_t           r_op;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wr_data;

  logic [1:0]        w_req;
  logic              w_pick_valid;
  mid_t              w_pick_id;
  logic              w_pick_wr;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_data;

  logic              w_grant;
  logic              w_ack;
  logic              w_err;
  logic              w_timeout;
  logic [DATA_W-1:0] w_rd_data;

  // A master requests while either enable is high.
  assign w_req = {(m1_rd_en | m1_wr_en), (m0_rd_en | m0_wr_en)};

  bus_rr_pick u_pick (
    .req       (w_req),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_pick_valid),
    .gnt_id    (w_pick_id)
  );

  // Both enables high from one master is a write, so wr_en alone decides.
  assign w_pick_wr   = w_pick_id ? m1_wr_en   : m0_wr_en;
  assign w_pick_addr = w_pick_id ? m1_addr    : m0_addr;
  assign w_pick_data = w_pick_id ? m1_wr_data : m0_wr_data;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Valid takes priority over the timeout in the same cycle.
  assign w_timeout = (r_state == ST_WAIT) && !s_rd_valid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // WAIT cycle counter: cleared on the strobe cycle, counts while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !s_rd_valid && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_rd_data   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_op == OP_WR) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_rd_valid) begin
          w_ack       = 1'b1;
          w_rd_data   = s_rd_data;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_ack       = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and slave-side address/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_op        <= OP_WR;
      r_s_addr    <= '0;
      r_s_wr_data <= '0;
    end else if (w_grant) begin
      r_gnt       <= w_pick_id;
      r_last_gnt  <= w_pick_id;
      r_op        <= w_pick_wr ? OP_WR : OP_RD;
      r_s_addr    <= w_pick_addr;
      r_s_wr_data <= w_pick_data;
    end
  end

  assign s_addr    = r_s_addr;
  assign s_wr_data = r_s_wr_data;
  assign s_rd_en   = (r_state == ST_ISSUE) && (r_op == OP_RD);
  assign s_wr_en   = (r_state == ST_ISSUE) && (r_op == OP_WR);

  // Completion is routed only to the granted master.
  assign m0_ack     = w_ack && (r_gnt == 1'b0);
  assign m1_ack     = w_ack && (r_gnt == 1'b1);
  assign m0_err     = w_err && (r_gnt == 1'b0);
  assign m1_err     = w_err && (r_gnt == 1'b1);
  assign m0_rd_data = (r_gnt == 1'b0) ? w_rd_data : '0;
  assign m1_rd_data = (r_gnt == 1'b1) ? w_rd_data : '0;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Timeout checks follow
// BUS_ARB_TIMEOUT_EN when it is defined for the build.
module tb_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] m0_addr = '0;
  logic          m0_rd_en = 1'b0;
  logic          m0_wr_en = 1'b0;
  logic [DW-1:0] m0_wr_data = '0;
  logic [DW-1:0] m0_rd_data;
  logic          m0_ack;
  logic          m0_err;
  logic [AW-1:0] m1_addr = '0;
  logic          m1_rd_en = 1'b0;
  logic          m1_wr_en = 1'b0;
  logic [DW-1:0] m1_wr_data = '0;
  logic [DW-1:0] m1_rd_data;
  logic          m1_ack;
  logic          m1_err;
  logic [AW-1:0] s_addr;
  logic          s_rd_en;
  logic          s_wr_en;
  logic [DW-1:0] s_wr_data;
  logic [DW-1:0] s_rd_data = '0;
  logic          s_rd_valid = 1'b0;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_addr     (m0_addr),
    .m0_rd_en    (m0_rd_en),
    .m0_wr_en    (m0_wr_en),
    .m0_wr_data  (m0_wr_data),
    .m0_rd_data  (m0_rd_data),
    .m0_ack      (m0_ack),
    .m0_err      (m0_err),
    .m1_addr     (m1_addr),
    .m1_rd_en    (m1_rd_en),
    .m1_wr_en    (m1_wr_en),
    .m1_wr_data  (m1_wr_data),
    .m1_rd_data  (m1_rd_data),
    .m1_ack      (m1_ack),
    .m1_err      (m1_err),
    .s_addr      (s_addr),
    .s_rd_en     (s_rd_en),
    .s_wr_en     (s_wr_en),
    .s_wr_data   (s_wr_data),
    .s_rd_data   (s_rd_data),
    .s_rd_valid  (s_rd_valid),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (output sample point).
  task automatic look();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_m0(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_rd_en = rd; m0_wr_en = wr; m0_addr = a; m0_wr_data = d;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_rd_en = rd; m1_wr_en = wr; m1_addr = a; m1_wr_data = d;
  endtask

  initial begin
    logic [0:0] exp_id;
    int ack_seen;

    // Reset values.
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    look();
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_s_rd_en", 32'(s_rd_en), 32'd0);
    chk("rst_s_wr_en", 32'(s_wr_en), 32'd0);
    chk("rst_s_addr", 32'(s_addr), 32'd0);
    chk("rst_s_wr_data", s_wr_data, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_errs", {30'd0, m1_err, m0_err}, 32'd0);
    chk("rst_rd_data", m0_rd_data | m1_rd_data, 32'd0);

    // m0 write, no contention.
    tick();
    drive_m0(1'b0, 1'b1, 16'h0010, 32'h0000_1234);
    look();
    chk("wr_req_cycle_no_strobe", 32'(s_wr_en), 32'd0);
    tick();
    look();
    chk("wr_s_wr_en", 32'(s_wr_en), 32'd1);
    chk("wr_s_rd_en", 32'(s_rd_en), 32'd0);
    chk("wr_s_addr", 32'(s_addr), 32'h0010);
    chk("wr_s_wr_data", s_wr_data, 32'h0000_1234);
    chk("wr_m0_ack", 32'(m0_ack), 32'd1);
    chk("wr_m1_ack", 32'(m1_ack), 32'd0);
    tick();
    drive_m0(1'b0, 1'b0, '0, '0);
    look();
    chk("wr_strobe_one_cycle", 32'(s_wr_en), 32'd0);
    chk("wr_ack_one_cycle", 32'(m0_ack), 32'd0);

    // m1 read with a registered slave.
    tick();
    drive_m1(1'b1, 1'b0, 16'h8004, '0);
    tick();
    look();
    chk("rd_s_rd_en", 32'(s_rd_en), 32'd1);
    chk("rd_s_addr", 32'(s_addr), 32'h8004);
    chk("rd_no_early_ack", 32'(m1_ack), 32'd0);
    tick();
    s_rd_valid = 1'b1; s_rd_data = 32'hDEAD_BEEF;
    look();
    chk("rd_m1_ack", 32'(m1_ack), 32'd1);
    chk("rd_m1_rd_data", m1_rd_data, 32'hDEAD_BEEF);
    chk("rd_m0_rd_data", m0_rd_data, 32'd0);
    chk("rd_m0_ack", 32'(m0_ack), 32'd0);
    chk("rd_m1_err", 32'(m1_err), 32'd0);
    tick();
    s_rd_valid = 1'b0; s_rd_data = '0;
    drive_m1(1'b0, 1'b0, '0, '0);
    look();
    chk("rd_ack_dropped", 32'(m1_ack), 32'd0);
    chk("rd_data_zero_no_ack", m1_rd_data, 32'd0);

    // Contention right after reset: grants alternate m0, m1, m0, m1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_m0(1'b0, 1'b1, 16'h0100, 32'hAAAA_0000);
    drive_m1(1'b0, 1'b1, 16'h0200, 32'hBBBB_1111);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      look();
      exp_id = exp_q.pop_front();
      chk($sformatf("rr_m0_ack_%0d", i), 32'(m0_ack), 32'(!exp_id));
      chk($sformatf("rr_m1_ack_%0d", i), 32'(m1_ack), 32'(exp_id));
      chk($sformatf("rr_wr_data_%0d", i), s_wr_data,
          (exp_id == 1'b1) ? 32'hBBBB_1111 : 32'hAAAA_0000);
      tick();
    end
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0);
    tick();

    // Read of unmapped space: slave never answers.
    drive_m0(1'b1, 1'b0, 16'h2000, '0);
    s_rd_data = 32'h1357_9BDF;
    tick();
    tick();
`ifdef BUS_ARB_TIMEOUT_EN
    ack_seen = 0;
    for (int k = 0; k < 15; k++) begin
      look();
      if (m0_ack) ack_seen++;
      tick();
    end
    chk("to_no_early_ack", 32'(ack_seen), 32'd0);
    look();
    chk("to_m0_ack", 32'(m0_ack), 32'd1);
    chk("to_m0_err", 32'(m0_err), 32'd1);
    chk("to_m0_rd_data", m0_rd_data, 32'd0);
    chk("to_m1_err", 32'(m1_err), 32'd0);
    tick();
    drive_m0(1'b0, 1'b0, '0, '0);
    look();
    chk("to_back_idle", 32'(dbg_state), 32'd0);
`else
    ack_seen = 0;
    for (int k = 0; k < 100; k++) begin
      look();
      if (m0_ack || m0_err) ack_seen++;
      tick();
    end
    chk("noto_no_ack_100", 32'(ack_seen), 32'd0);
    chk("noto_still_wait", 32'(dbg_state), 32'd2);
    s_rd_valid = 1'b1; s_rd_data = 32'h0BAD_F00D;
    look();
    chk("noto_late_ack", 32'(m0_ack), 32'd1);
    chk("noto_late_data", m0_rd_data, 32'h0BAD_F00D);
    tick();
    s_rd_valid = 1'b0;
    drive_m0(1'b0, 1'b0, '0, '0);
`endif
    s_rd_data = '0;
    tick();

    // Reset during WAIT, then a late valid pulse.
    drive_m1(1'b1, 1'b0, 16'h0040, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_m1(1'b0, 1'b0, '0, '0);
    s_rd_valid = 1'b1; s_rd_data = 32'h5555_5555;
    look();
    chk("rstw_m1_ack", 32'(m1_ack), 32'd0);
    chk("rstw_m1_rd_data", m1_rd_data, 32'd0);
    chk("rstw_state", 32'(dbg_state), 32'd0);
    chk("rstw_s_addr", 32'(s_addr), 32'd0);
    tick();
    s_rd_valid = 1'b0; s_rd_data = '0;
    drive_m1(1'b0, 1'b1, 16'h0044, 32'h0000_0099);
    tick();
    look();
    chk("rstw_next_m1_ack", 32'(m1_ack), 32'd1);
    chk("rstw_next_s_wr_en", 32'(s_wr_en), 32'd1);
    chk("rstw_next_s_addr", 32'(s_addr), 32'h0044);
    tick();
    drive_m1(1'b0, 1'b0, '0, '0);

    // Stale valid in IDLE, then a write with both enables high.
    s_rd_valid = 1'b1; s_rd_data = 32'hAAAA_AAAA;
    look();
    chk("stale_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("stale_rd_data", m0_rd_data | m1_rd_data, 32'd0);
    tick();
    s_rd_valid = 1'b0; s_rd_data = '0;
    drive_m0(1'b1, 1'b1, 16'h0030, 32'h0000_0077);
    tick();
    look();
    chk("rdwr_s_wr_en", 32'(s_wr_en), 32'd1);
    chk("rdwr_s_rd_en", 32'(s_rd_en), 32'd0);
    chk("rdwr_m0_ack", 32'(m0_ack), 32'd1);
    chk("rdwr_s_wr_data", s_wr_data, 32'h0000_0077);
    tick();
    drive_m0(1'b0, 1'b0, '0, '0);
    look();
    chk("rdwr_idle_after", 32'(dbg_state), 32'd0);
    chk("rdwr_no_rd_strobe", 32'(s_rd_en), 32'd0);

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the system memory/peripheral bus. It sits between the masters (CPU, plus a second master such as a DMA or debug port) and the address decoder that fans out to bram/spram/led/uart.
- Serialises accesses, using round-robin when both masters request.
- Converts level-held master requests into single-cycle slave strobes.
- Returns read data and a per-master acknowledge.
- Times out reads to unmapped space, which never raise rd_valid.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT_CYCLES, 15, WAIT cycles before a read is aborted (used only with BUS_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_addr  in  ADDR_W  master 0 address
- m0_rd_en  in  1  master 0 read request (level)
- m0_wr_en  in  1  master 0 write request (level)
- m0_wr_data  in  DATA_W  master 0 write data
- m0_rd_data  out  DATA_W  master 0 read data, valid with m0_ack
- m0_ack  out  1  master 0 transfer complete (1-cycle pulse)
- m0_err  out  1  master 0 read timed out (pulse with m0_ack)
- m1_addr, m1_rd_en, m1_wr_en, m1_wr_data, m1_rd_data, m1_ack, m1_err: same as m0, for master 1
- s_addr  out  ADDR_W  slave address (registered)
- s_rd_en  out  1  slave read strobe (1 cycle)
- s_wr_en  out  1  slave write strobe (1 cycle)
- s_wr_data  out  DATA_W  slave write data (registered)
- s_rd_data  in  DATA_W  slave read data
- s_rd_valid  in  1  slave read data valid

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-high (rst). All state updates on posedge clk.
- Master protocol:
  - A master raises rd_en or wr_en, holding addr and wr_data stable, until it sees its ack.
  - A master drops its request on the cycle after ack.
  - rd_en and wr_en both high from one master: treated as a write.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Sample requests. One requester: grant it. Both requesting: grant the master that is not last_gnt.
  - On grant: latch the master id into gnt; register s_addr, s_wr_data and the operation; go to ISSUE. Update last_gnt.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - s_rd_en or s_wr_en is high for this single cycle only.
  - Write: mX_ack=1 in this cycle (the slave samples at the closing edge); next state IDLE.
  - Read: next state WAIT; the timeout counter clears to 0.
- WAIT:
  - On s_rd_valid: mX_rd_data=s_rd_data (combinational pass-through) and mX_ack=1; next state IDLE.
  - Otherwise the counter increments.
- Timing:
  - Write: request seen in cycle N; strobe and ack in N+1; next grant possible at N+2.
  - Read: strobe in N+1; a registered slave (1-cycle rd_valid) produces ack in N+2; next grant possible at N+3.
- s_rd_valid seen outside WAIT is ignored (stale data).
- mX_rd_data is 0 whenever mX_ack is low or the transfer was a write.
- Only the granted master ever sees ack or err. The non-granted ack is 0.
- Fairness: a waiting master is served next; it waits at most one transfer of the other master.
- Reset values:
  - state=IDLE, last_gnt=1 (m0 wins the first tie).
  - s_rd_en=s_wr_en=0, s_addr=0, s_wr_data=0.
  - All ack/err/rd_data outputs = 0.
- Reset mid-transfer: the transfer is abandoned with no ack; a late s_rd_valid after reset is ignored.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - In WAIT, when the counter reaches TIMEOUT_CYCLES with no s_rd_valid: mX_ack=1, mX_err=1, mX_rd_data=0; next state IDLE.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
  - If s_rd_valid arrives in the same cycle as the timeout, valid wins and err=0.
- Undefined:
  - No counter is built; WAIT holds indefinitely until s_rd_valid.
  - m0_err and m1_err are tied to 0.

Decomposition:
- Package bus_pkg:
  - ADDR_W, DATA_W defaults
  - state enum (IDLE/ISSUE/WAIT)
  - master-id type (1 bit)
  - op type (RD/WR)
- Sub-module bus_rr_pick: combinational 2-way round-robin picker. Inputs req[1:0] and last_gnt; outputs gnt_valid and gnt_id. Instantiated once.

Test Plan:
- m0 write 0x0000_1234 to addr 0x0010, no contention -> s_wr_en=1 one cycle with s_addr=0x0010, s_wr_data=0x1234; m0_ack in the same cycle; m1_ack stays 0.
- m1 read of 0x8004, slave returns 0xDEADBEEF one cycle after the strobe -> m1_ack and m1_rd_data=0xDEADBEEF 2 cycles after the request is first sampled; m0_rd_data=0.
- m0 and m1 request in the same cycle right after reset -> m0 granted first, m1 next; with both held continuously, grants alternate m0,m1,m0,m1.
- Read of unmapped 0x2000 with BUS_ARB_TIMEOUT_EN defined -> ack and err after 15 WAIT cycles, rd_data=0. Without the macro -> no ack through a 100-cycle window.
- rst asserted during WAIT, then s_rd_valid pulses the next cycle -> no ack; outputs at reset values; a subsequent m1 request is granted normally.
- s_rd_valid pulse injected while in IDLE, and a write with rd_en and wr_en both high -> the pulse is ignored; the transfer is issued as a write only (s_rd_en stays 0).
